addr_port_arbiter: RTL and testbench

ADDR_PORT_ARBITER -- requirements
Module: addr_port_arbiter

---
 rtl/addr_port_arbiter_pkg.sv | 35 +++
 rtl/addr_port_arbiter_lat_counter.sv | 31 +++
 rtl/addr_port_arbiter.sv | 91 +++++++++
 tb/tb_addr_port_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/addr_port_arbiter_pkg.sv
// Shared types and constants for the two-port address-register arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package addr_port_arbiter_pkg;

    localparam int ADDR_W = 12;
    localparam int CNT_W  = 4;

    // Port indices into req/grant/done.
    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Transaction captured when a port wins arbitration.
    typedef struct packed {
        logic  port;
        logic  we;
        addr_t addr;
    } xact_t;

    function automatic logic [1:0] port_onehot(input logic port);
        logic [1:0] oh;
        oh       = 2'b00;
        oh[port] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/addr_port_arbiter_lat_counter.sv
// Loadable down-counter timing the memory wait phase; zero flag marks the final wait cycle.
// Latency: load takes effect on the next clock; count saturates at zero.
// Backpressure: none; dec is ignored once the count reaches zero.
//
// Ports: clk/clr (sync active-high), load + load_val (preset), dec (count down), zero (count == 0).
module lat_counter
    import addr_port_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/addr_port_arbiter.sv
// Round-robin arbiter giving fetch (0) and data (1) ports ownership of a shared address register.
// Latency: req seen in IDLE -> LOAD next cycle -> MEM_LAT wait cycles, done on the last -> back to IDLE.
// Backpressure: requesters hold req until their done pulse; a losing port simply waits in req.
//
// Ports: clk, clr (sync active-high); req[1:0], addr0, addr1, we1 from the ports;
//        grant[1:0], done[1:0] back to the ports; areg_d/areg_en to the shared register;
//        mem_we write strobe; busy whenever a transaction is in flight.
module addr_port_arbiter
    import addr_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT = 2   // legal 1..15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [1:0]        req,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              we1,
    output logic [1:0]        grant,
    output logic [1:0]        done,
    output logic [ADDR_W-1:0] areg_d,
    output logic              areg_en,
    output logic              mem_we,
    output logic              busy
);

    // Counter starts at MEM_LAT-1 so its zero cycle is the MEM_LAT-th wait cycle.
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT - 1);

    state_t state;
    state_t state_nxt;
    logic   lp;          // last granted port; reset to data so fetch wins the first tie
    logic   win_port;
    xact_t  xact;
    logic   cnt_zero;

    // Winner among current requests; on a tie the port not granted last time wins.
    always_comb begin
        win_port = PORT_FETCH;
        if (req == 2'b10) begin
            win_port = PORT_DATA;
        end else if (req == 2'b11) begin
            win_port = ~lp;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = LOAD;
            LOAD:    state_nxt = WAIT;
            WAIT:    if (cnt_zero) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            lp    <= PORT_DATA;
            xact  <= '0;
        end else begin
            state <= state_nxt;
            // Snapshot the winner's request; later input changes cannot disturb it.
            if ((state == IDLE) && (|req)) begin
                lp        <= win_port;
                xact.port <= win_port;
                xact.we   <= (win_port == PORT_DATA) ? we1 : 1'b0;
                xact.addr <= (win_port == PORT_DATA) ? addr1 : addr0;
            end
        end
    end

    lat_counter u_lat_counter (
        .clk      (clk),
        .clr      (clr),
        .load     (state == LOAD),
        .dec      (state == WAIT),
        .load_val (LAT_INIT),
        .zero     (cnt_zero)
    );

    // All outputs decode registered state only.
    assign busy    = (state != IDLE);
    assign grant   = busy ? port_onehot(xact.port) : 2'b00;
    assign done    = ((state == WAIT) && cnt_zero) ? port_onehot(xact.port) : 2'b00;
    assign areg_en = (state == LOAD);
    assign areg_d  = areg_en ? xact.addr : '0;
    assign mem_we  = (state == WAIT) && xact.we;

endmodule

// File: tb/tb_addr_port_arbiter.sv
// Directed bench for addr_port_arbiter with MEM_LAT=2 and MEM_LAT=3 instances on shared stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_addr_port_arbiter;

    logic        clk;
    logic        clr;
    logic [1:0]  req;
    logic [11:0] addr0;
    logic [11:0] addr1;
    logic        we1;

    logic [1:0]  g2, d2, g3, d3;
    logic [11:0] ad2, ad3;
    logic        ae2, mw2, b2, ae3, mw3, b3;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [1:0]  g;
        logic [11:0] a;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    logic [1:0] eg;

    addr_port_arbiter #(.MEM_LAT(2)) u_dut2 (
        .clk(clk), .clr(clr), .req(req), .addr0(addr0), .addr1(addr1), .we1(we1),
        .grant(g2), .done(d2), .areg_d(ad2), .areg_en(ae2), .mem_we(mw2), .busy(b2)
    );

    addr_port_arbiter #(.MEM_LAT(3)) u_dut3 (
        .clk(clk), .clr(clr), .req(req), .addr0(addr0), .addr1(addr1), .we1(we1),
        .grant(g3), .done(d3), .areg_d(ad3), .areg_en(ae3), .mem_we(mw3), .busy(b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic push(input logic [1:0] g, input logic [11:0] a);
        exp_q.push_back('{g: g, a: a});
    endtask

    // Every address load on the MEM_LAT=2 instance must match the next expected grant/address.
    always @(negedge clk) begin
        if (ae2 === 1'b1) begin
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL sb_unexpected_load: observed grant=%0h areg_d=%0h, required no load", g2, ad2);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_grant", {30'd0, g2}, {30'd0, e.g});
                check("sb_areg_d", {20'd0, ad2}, {20'd0, e.a});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held while both ports request: clr must win.
        clr = 1'b1; req = 2'b11; addr0 = 12'h5A5; addr1 = 12'hA5A; we1 = 1'b1;
        step(); step();
        check("rst_grant2", g2, 2'b00);
        check("rst_done2", d2, 2'b00);
        check("rst_areg_en2", ae2, 0);
        check("rst_areg_d2", ad2, 0);
        check("rst_mem_we2", mw2, 0);
        check("rst_busy2", b2, 0);
        check("rst_busy3", b3, 0);
        check("rst_grant3", g3, 2'b00);

        // Single fetch, MEM_LAT=2: t=0 request.
        clr = 1'b0; req = 2'b01; addr0 = 12'h0A5; we1 = 1'b0;
        push(2'b01, 12'h0A5);
        step(); // t=1 LOAD
        check("f_grant_t1", g2, 2'b01);
        check("f_areg_en_t1", ae2, 1);
        check("f_areg_d_t1", ad2, 12'h0A5);
        check("f_busy_t1", b2, 1);
        step(); // t=2 WAIT
        check("f_grant_t2", g2, 2'b01);
        check("f_done_t2", d2, 2'b00);
        check("f_areg_en_t2", ae2, 0);
        check("f_areg_d_t2", ad2, 0);
        step(); // t=3 final WAIT
        check("f_grant_t3", g2, 2'b01);
        check("f_done_t3", d2, 2'b01);
        check("f_mem_we_t3", mw2, 0);
        req = 2'b00;
        step(); // t=4 IDLE
        check("f_busy_t4", b2, 0);
        check("f_grant_t4", g2, 2'b00);
        check("f_done_t4", d2, 2'b00);

        // Both ports held: grants alternate 0,1,0,1.
        do_reset();
        req = 2'b11; addr0 = 12'h111; addr1 = 12'h222; we1 = 1'b0;
        for (int i = 0; i < 4; i++) push((i % 2 == 0) ? 2'b01 : 2'b10, (i % 2 == 0) ? 12'h111 : 12'h222);
        for (int i = 0; i < 4; i++) begin
            eg = (i % 2 == 0) ? 2'b01 : 2'b10;
            step();
            check("alt_load_grant", g2, eg);
            step(); step();
            check("alt_done", d2, eg);
            if (i == 3) req = 2'b00;
            step();
            check("alt_idle_busy", b2, 0);
        end

        // Data-port write, MEM_LAT=3; we1 dropped after capture must not matter.
        do_reset();
        req = 2'b10; addr1 = 12'hFFF; we1 = 1'b1;
        push(2'b10, 12'hFFF);
        step(); // LOAD
        check("w_areg_en3", ae3, 1);
        check("w_areg_d3", ad3, 12'hFFF);
        check("w_grant3", g3, 2'b10);
        check("w_mem_we_load3", mw3, 0);
        req = 2'b00; we1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("w_mem_we3", mw3, 1);
            check("w_done3", d3, (k == 2) ? 2'b10 : 2'b00);
        end
        step();
        check("w_mem_we_after3", mw3, 0);
        check("w_busy_after3", b3, 0);

        // Address change after capture: no new load, stale address not replaced.
        do_reset();
        req = 2'b10; addr1 = 12'h100; we1 = 1'b0;
        push(2'b10, 12'h100);
        step(); // LOAD
        check("ic_areg_d_load", ad2, 12'h100);
        step(); // WAIT1
        addr1 = 12'h200;
        check("ic_areg_en_w1", ae2, 0);
        check("ic_areg_d_w1", ad2, 0);
        check("ic_mem_we_w1", mw2, 0);
        step(); // WAIT2
        check("ic_done_w2", d2, 2'b10);
        req = 2'b00;
        step();
        check("ic_busy_idle", b2, 0);

        // clr during second wait cycle of the MEM_LAT=3 instance.
        do_reset();
        req = 2'b01; addr0 = 12'h333;
        push(2'b01, 12'h333);
        step(); // LOAD
        step(); // WAIT1
        step(); // WAIT2
        check("r_grant_w2_3", g3, 2'b01);
        check("r_done_w2_3", d3, 2'b00);
        clr = 1'b1;
        step();
        check("r_grant3", g3, 2'b00);
        check("r_done3", d3, 2'b00);
        check("r_areg_en3", ae3, 0);
        check("r_areg_d3", ad3, 0);
        check("r_mem_we3", mw3, 0);
        check("r_busy3", b3, 0);
        // lp must be back to 1: a tie now goes to the fetch port.
        clr = 1'b0; req = 2'b11; addr0 = 12'h444; addr1 = 12'h555;
        push(2'b01, 12'h444);
        step();
        check("r_done_after3", d3, 2'b00);
        check("r_tie_grant3", g3, 2'b01);
        check("r_tie_areg_d3", ad3, 12'h444);
        req = 2'b00;
        step(); step(); step();
        check("r_tie_done3", d3, 2'b01);
        step();

        // Request dropped in LOAD: done still pulses at t+1+MEM_LAT.
        do_reset();
        req = 2'b01; addr0 = 12'h0C3;
        push(2'b01, 12'h0C3);
        step(); // LOAD
        req = 2'b00;
        step();
        check("dr_done_w1", d2, 2'b00);
        step();
        check("dr_done_w2", d2, 2'b01);
        step();
        check("dr_done_idle", d2, 2'b00);
        check("dr_busy_idle", b2, 0);

        step(); step();
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
